instr_aligner: RTL and testbench

Sits between the fetch stage and the instruction decoder. Splits 32-bit fetched words into RVI/RVC instructions. Keeps a one-halfword residual for instructions that straddle words. Tracks the halfword PC of every issued instruction. Drives the decoder-side inputs: aligned instruction, fetch error code, prediction flag and alignment-error flag. Its output is a registered valid/ready slot feeding the ID stage.

---
 rtl/instr_aligner.sv | 179 +++++++++++++++++
 tb/tb_instr_aligner.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// Splits fetched 32-bit words into RVI/RVC instructions, carrying one halfword
// across word boundaries, and presents them through a registered valid/ready slot.
module instr_aligner #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter logic [2:0]  FETCH_VALID = 3'd0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic [31:0] s_flush_addr_i,
  input  logic        s_fetch_valid_i,
  output logic        s_fetch_ready_o,
  input  logic [31:0] s_fetch_data_i,
  input  logic [2:0]  s_fetch_error_i,
  input  logic        s_fetch_pred_i,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_instr_o,
  output logic [31:0] s_pc_o,
  output logic [2:0]  s_fetch_error_o,
  output logic        s_prediction_o,
  output logic        s_align_error_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  err_q, err_d;
  logic        pred_q, pred_d;
  logic        aerr_q, aerr_d;
  logic [15:0] res_q, res_d;
  logic        res_v_q, res_v_d;
  logic [2:0]  res_err_q, res_err_d;
  logic        res_pred_q, res_pred_d;
  logic        skip_q, skip_d;
  logic [30:0] npc_q, npc_d;

  logic        load;
  logic        res_rvc;
  logic        issue;
  logic        issue_rvi;
  logic        unused_addr_bit;

  assign load            = ~valid_q | s_ready_i;
  assign res_rvc         = (res_q[1:0] != 2'b11);
  assign unused_addr_bit = s_flush_addr_i[0];

  assign s_fetch_ready_o = ~s_flush_i &
                           ((skip_q & ~res_v_q & s_fetch_valid_i) |
                            (load & ~res_v_q) |
                            (load & res_v_q & ~res_rvc & ~res_pred_q));

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    err_d      = err_q;
    pred_d     = pred_q;
    aerr_d     = aerr_q;
    res_d      = res_q;
    res_v_d    = res_v_q;
    res_err_d  = res_err_q;
    res_pred_d = res_pred_q;
    skip_d     = skip_q;
    npc_d      = npc_q;
    issue      = 1'b0;
    issue_rvi  = 1'b0;

    if (s_flush_i) begin
      res_v_d = 1'b0;
      valid_d = 1'b0;
      skip_d  = s_flush_addr_i[1];
      npc_d   = s_flush_addr_i[31:1];
    end else begin
      if (res_v_q && load) begin
        if (res_rvc) begin
          issue   = 1'b1;
          instr_d = {16'h0, res_q};
          err_d   = res_err_q;
          pred_d  = res_pred_q;
          aerr_d  = 1'b0;
          res_v_d = 1'b0;
        end else if (res_pred_q) begin
          // The predictor redirected in the middle of an RVI: flag it instead of stitching.
          issue   = 1'b1;
          instr_d = {16'h0, res_q};
          err_d   = res_err_q;
          pred_d  = 1'b1;
          aerr_d  = 1'b1;
          res_v_d = 1'b0;
        end else if (s_fetch_valid_i) begin
          issue      = 1'b1;
          issue_rvi  = 1'b1;
          instr_d    = {s_fetch_data_i[15:0], res_q};
          err_d      = (res_err_q != FETCH_VALID) ? res_err_q : s_fetch_error_i;
          pred_d     = 1'b0;
          aerr_d     = 1'b0;
          res_d      = s_fetch_data_i[31:16];
          res_err_d  = s_fetch_error_i;
          res_pred_d = s_fetch_pred_i;
        end
      end else if (!res_v_q && skip_q && s_fetch_valid_i) begin
        res_d      = s_fetch_data_i[31:16];
        res_err_d  = s_fetch_error_i;
        res_pred_d = s_fetch_pred_i;
        res_v_d    = 1'b1;
        skip_d     = 1'b0;
      end else if (!res_v_q && !skip_q && load && s_fetch_valid_i) begin
        issue  = 1'b1;
        aerr_d = 1'b0;
        if (s_fetch_error_i != FETCH_VALID) begin
          issue_rvi = 1'b1;
          instr_d   = s_fetch_data_i;
          err_d     = s_fetch_error_i;
          pred_d    = s_fetch_pred_i;
        end else if (s_fetch_data_i[1:0] != 2'b11) begin
          instr_d    = {16'h0, s_fetch_data_i[15:0]};
          err_d      = s_fetch_error_i;
          pred_d     = 1'b0;
          res_d      = s_fetch_data_i[31:16];
          res_err_d  = s_fetch_error_i;
          res_pred_d = s_fetch_pred_i;
          res_v_d    = 1'b1;
        end else begin
          issue_rvi = 1'b1;
          instr_d   = s_fetch_data_i;
          err_d     = s_fetch_error_i;
          pred_d    = s_fetch_pred_i;
        end
      end

      if (issue) begin
        valid_d = 1'b1;
        pc_d    = {npc_q, 1'b0};
        npc_d   = npc_q + (issue_rvi ? 31'd2 : 31'd1);
      end else if (load) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc_q       <= {PC_RESET[31:1], 1'b0};
      err_q      <= FETCH_VALID;
      pred_q     <= 1'b0;
      aerr_q     <= 1'b0;
      res_q      <= 16'h0;
      res_v_q    <= 1'b0;
      res_err_q  <= FETCH_VALID;
      res_pred_q <= 1'b0;
      skip_q     <= 1'b0;
      npc_q      <= PC_RESET[31:1];
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      pred_q     <= pred_d;
      aerr_q     <= aerr_d;
      res_q      <= res_d;
      res_v_q    <= res_v_d;
      res_err_q  <= res_err_d;
      res_pred_q <= res_pred_d;
      skip_q     <= skip_d;
      npc_q      <= npc_d;
    end
  end

  assign s_valid_o       = valid_q;
  assign s_instr_o       = instr_q;
  assign s_pc_o          = pc_q;
  assign s_fetch_error_o = err_q;
  assign s_prediction_o  = pred_q;
  assign s_align_error_o = aerr_q;

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed scenarios plus random traffic scored against
// a halfword-stream parser model.
module tb_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = 32'h0;
  logic [2:0]  fetch_err = 3'd0;
  logic        fetch_pred = 1'b0;
  logic        valid;
  logic        ready_in = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  err_o;
  logic        pred_o;
  logic        aerr_o;

  always #5 clk = ~clk;

  instr_aligner dut (
    .s_clk_i         (clk),
    .s_resetn_i      (rst_n),
    .s_flush_i       (flush),
    .s_flush_addr_i  (flush_addr),
    .s_fetch_valid_i (fetch_valid),
    .s_fetch_ready_o (fetch_ready),
    .s_fetch_data_i  (fetch_data),
    .s_fetch_error_i (fetch_err),
    .s_fetch_pred_i  (fetch_pred),
    .s_valid_o       (valid),
    .s_ready_i       (ready_in),
    .s_instr_o       (instr),
    .s_pc_o          (pc),
    .s_fetch_error_o (err_o),
    .s_prediction_o  (pred_o),
    .s_align_error_o (aerr_o)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: accepted words become a halfword stream that is parsed into instructions.
  typedef struct { logic [15:0] d; logic [2:0] e; logic p; } hw_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [2:0] e; logic p; logic a; } ins_t;

  hw_t         pend[$];
  ins_t        expq[$];
  logic        m_skip = 1'b0;
  logic [31:0] m_pc = 32'h0;

  function automatic void m_issue(logic [31:0] i, int len, logic [2:0] e, logic p, logic a);
    ins_t t;
    t.instr = i; t.pc = m_pc; t.e = e; t.p = p; t.a = a;
    expq.push_back(t);
    m_pc = m_pc + 32'(len);
  endfunction

  function automatic void m_word(logic [31:0] w, logic [2:0] e, logic p);
    hw_t lo, hi, h, h1;
    lo.d = w[15:0];  lo.e = e; lo.p = 1'b0;
    hi.d = w[31:16]; hi.e = e; hi.p = p;
    if (m_skip) begin
      m_skip = 1'b0;
      pend.push_back(hi);
    end else if (pend.size() == 0 && e != 3'd0) begin
      m_issue(w, 4, e, p, 1'b0);
    end else begin
      pend.push_back(lo);
      pend.push_back(hi);
    end
    while (pend.size() > 0) begin
      h = pend[0];
      if (h.d[1:0] != 2'b11) begin
        m_issue({16'h0, h.d}, 2, h.e, h.p, 1'b0);
        void'(pend.pop_front());
      end else if (h.p) begin
        m_issue({16'h0, h.d}, 2, h.e, 1'b1, 1'b1);
        void'(pend.pop_front());
      end else if (pend.size() >= 2) begin
        h1 = pend[1];
        m_issue({h1.d, h.d}, 4, (h.e != 3'd0) ? h.e : h1.e, h1.p, 1'b0);
        void'(pend.pop_front());
        void'(pend.pop_front());
      end else begin
        break;
      end
    end
  endfunction

  logic        held = 1'b0;
  logic [31:0] h_instr, h_pc;
  logic [4:0]  h_meta;
  ins_t        mon_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      expq.delete();
      m_skip = 1'b0;
      m_pc   = 32'h0;
      held   = 1'b0;
    end else begin
      if (held) begin
        check_val("hold_valid", {31'h0, valid}, 32'h1);
        check_val("hold_instr", instr, h_instr);
        check_val("hold_pc", pc, h_pc);
        check_val("hold_meta", {27'h0, err_o, pred_o, aerr_o}, {27'h0, h_meta});
      end
      held = valid & ~ready_in & ~flush;
      if (held) begin
        h_instr = instr;
        h_pc    = pc;
        h_meta  = {err_o, pred_o, aerr_o};
        if (!m_skip) check_val("hold_fetch_ready", {31'h0, fetch_ready}, 32'h0);
      end
      if (valid && ready_in) begin
        if (expq.size() == 0) begin
          check_val("spurious_issue", {31'h0, valid}, 32'h0);
        end else begin
          mon_t = expq.pop_front();
          check_val("sb_instr", instr, mon_t.instr);
          check_val("sb_pc", pc, mon_t.pc);
          check_val("sb_meta", {27'h0, err_o, pred_o, aerr_o}, {27'h0, mon_t.e, mon_t.p, mon_t.a});
        end
      end
      if (flush) begin
        check_val("flush_fetch_ready", {31'h0, fetch_ready}, 32'h0);
        pend.delete();
        expq.delete();
        m_skip = flush_addr[1];
        m_pc   = {flush_addr[31:1], 1'b0};
      end else if (fetch_valid && fetch_ready) begin
        m_word(fetch_data, fetch_err, fetch_pred);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush = 1'b1;
    flush_addr = a;
    tick();
    flush = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] e, input logic p);
    bit ok = 1'b0;
    fetch_valid = 1'b1; fetch_data = d; fetch_err = e; fetch_pred = p;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = fetch_ready;
    end
    if (!ok) check_val("fetch_timeout", 32'h0, 32'h1);
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] i, input logic [31:0] p);
    bit ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      ok = valid & ready_in;
    end
    if (!ok) begin
      check_val({tag, "_timeout"}, 32'h0, 32'h1);
    end else begin
      check_val({tag, "_instr"}, instr, i);
      check_val({tag, "_pc"}, pc, p);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) b[1:0] = 2'b11;
    return {b, a};
  endfunction

  initial begin
    #1_000_000;
    check_val("watchdog", 32'h0, 32'h1);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", {31'h0, valid}, 32'h0);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_meta", {27'h0, err_o, pred_o, aerr_o}, 32'h0);
    rst_n = 1'b1;
    #1;
    check_val("rst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    tick();

    send_word(32'h00A00513, 3'd0, 1'b0);
    expect_issue("rvi", 32'h00A00513, 32'h0);
    tick();
    send_word(32'h45814501, 3'd0, 1'b0);
    expect_issue("rvc_lo", 32'h00004501, 32'h4);
    check_val("rvc_stall_ready", {31'h0, fetch_ready}, 32'h0);
    expect_issue("rvc_hi", 32'h00004581, 32'h6);

    tick();
    do_flush(32'h0000_0102);
    send_word(32'h05130001, 3'd0, 1'b0);
    send_word(32'h000000A0, 3'd0, 1'b0);
    expect_issue("straddle", 32'h00A00513, 32'h102);

    tick();
    do_flush(32'h0);
    send_word(32'h05134501, 3'd0, 1'b1);
    expect_issue("pred_lo", 32'h00004501, 32'h0);
    check_val("pred_lo_flag", {31'h0, pred_o}, 32'h0);
    expect_issue("aerr", 32'h00000513, 32'h2);
    check_val("aerr_flags", {30'h0, aerr_o, pred_o}, 32'h3);

    tick();
    send_word(32'h12344501, 3'd2, 1'b0);
    expect_issue("ferr", 32'h12344501, 32'h4);
    check_val("ferr_code", {29'h0, err_o}, 32'h2);
    tick();
    send_word(32'h00000001, 3'd0, 1'b0);
    expect_issue("ferr_next", 32'h00000001, 32'h8);
    repeat (3) tick();

    do_flush(32'h0);
    ready_in = 1'b0;
    send_word(32'h00A00513, 3'd0, 1'b0);
    fetch_valid = 1'b1; fetch_data = 32'h00B00593; fetch_err = 3'd0; fetch_pred = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_valid", {31'h0, valid}, 32'h1);
      check_val("bp_instr", instr, 32'h00A00513);
      check_val("bp_ready", {31'h0, fetch_ready}, 32'h0);
    end
    tick();
    ready_in = 1'b1;
    expect_issue("bp_a", 32'h00A00513, 32'h0);
    tick();
    fetch_valid = 1'b0;
    expect_issue("bp_b", 32'h00B00593, 32'h4);

    tick();
    do_flush(32'hFFFF_FFFC);
    send_word(32'h00A00513, 3'd0, 1'b0);
    expect_issue("wrap_a", 32'h00A00513, 32'hFFFF_FFFC);
    tick();
    send_word(32'h00A00513, 3'd0, 1'b0);
    expect_issue("wrap_b", 32'h00A00513, 32'h0);
    tick();

    for (int c = 0; c < 4000; c++) begin
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_data  = rand_word();
      fetch_err   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      fetch_pred  = ($urandom_range(0, 9) == 0);
      ready_in    = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 49) == 0);
      flush_addr  = $urandom() & 32'hFFFF_FFFE;
      tick();
    end
    flush = 1'b0;
    fetch_valid = 1'b0;
    ready_in = 1'b1;
    repeat (10) tick();
    check_val("drain_empty", 32'(expq.size()), 32'h0);

    fetch_valid = 1'b1; fetch_data = 32'h00A00513;
    ready_in = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    #1;
    check_val("arst_valid", {31'h0, valid}, 32'h0);
    check_val("arst_pc", pc, 32'h0);
    check_val("arst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    ready_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    send_word(32'h00A00513, 3'd0, 1'b0);
    expect_issue("post_rst", 32'h00A00513, 32'h0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
